// File: rtl/step_controller.sv
// step_controller: advances a PC from a divided free-run tick or a debounced single-step button,
// mirroring PC low bits and a heartbeat onto the board LEDs.
module step_controller #(
  parameter int DIV_BITS = 23,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PC_WIDTH = 64,
  parameter int PC_INC = 1,
  parameter int LED_COUNT = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic                 run_en,
  input  logic                 step_btn,
  input  logic                 pc_load,
  input  logic [PC_WIDTH-1:0]  pc_load_value,
  output logic                 step,
  output logic [PC_WIDTH-1:0]  pc,
  output logic [LED_COUNT-1:0] led
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int LW = LED_COUNT - 1;
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;
  state_t state, state_n;
  logic [DW-1:0] dcnt, dcnt_n;
  logic [DIV_BITS-1:0] div_cnt;
  logic s1, btn_s, dcnt_last, btn_req, tick_req, step_req;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      btn_s <= 1'b0;
      state <= IDLE;
      dcnt <= '0;
    end else begin
      s1 <= step_btn;
      btn_s <= s1;
      state <= state_n;
      dcnt <= dcnt_n;
    end
  end
  assign dcnt_last = dcnt == DW'(DEBOUNCE_CYCLES - 1);
  always_comb begin
    state_n = state;
    dcnt_n = dcnt;
    case (state)
      IDLE: if (btn_s) begin
        state_n = PRESS_WAIT;
        dcnt_n = '0;
      end
      PRESS_WAIT:
        if (!btn_s) state_n = IDLE;
        else if (dcnt_last) state_n = PRESSED;
        else dcnt_n = dcnt + 1'b1;
      PRESSED: if (!btn_s) begin
        state_n = RELEASE_WAIT;
        dcnt_n = '0;
      end
      default:
        if (btn_s) state_n = PRESSED;
        else if (dcnt_last) state_n = IDLE;
        else dcnt_n = dcnt + 1'b1;
    endcase
  end
  // One request per debounced press: only the PRESS_WAIT -> PRESSED transition raises it.
  always_comb btn_req = (state == PRESS_WAIT) && btn_s && dcnt_last;
  assign tick_req = (&div_cnt) & run_en & ~mode;
  assign step_req = tick_req | (btn_req & mode);
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      pc <= '0;
      step <= 1'b0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      pc <= pc_load ? pc_load_value : step_req ? pc + PC_WIDTH'(PC_INC) : pc;
      step <= ~pc_load & step_req;
    end
  end
  // Narrow PCs are zero-extended so the upper LEDs stay dark.
  if (PC_WIDTH >= LW) begin : g_led_wide
    assign led = {pc[LW-1:0], div_cnt[DIV_BITS-1]};
  end else begin : g_led_narrow
    assign led = {{(LW-PC_WIDTH){1'b0}}, pc, div_cnt[DIV_BITS-1]};
  end
endmodule

// File: tb/tb_step_controller.sv
// tb_step_controller: directed checks of free-run, single-step, debounce, load priority, wrap and reset.
module tb_step_controller;
  logic clk, rst;
  logic mode, run_en, step_btn, pc_load;
  logic [15:0] pc_load_value, pc;
  logic step;
  logic [9:0] led;
  logic w_mode, w_run_en, w_btn, w_load, w_step;
  logic [7:0] w_val, w_pc;
  logic [9:0] w_led;
  int checks = 0;
  int errors = 0;
  int nsteps;
  logic seen;

  step_controller #(.DIV_BITS(3), .DEBOUNCE_CYCLES(4), .PC_WIDTH(16), .PC_INC(1), .LED_COUNT(10)) dut (
    .clk(clk), .rst(rst), .mode(mode), .run_en(run_en), .step_btn(step_btn),
    .pc_load(pc_load), .pc_load_value(pc_load_value), .step(step), .pc(pc), .led(led)
  );

  step_controller #(.DIV_BITS(3), .DEBOUNCE_CYCLES(4), .PC_WIDTH(8), .PC_INC(4), .LED_COUNT(10)) dut_w (
    .clk(clk), .rst(rst), .mode(w_mode), .run_en(w_run_en), .step_btn(w_btn),
    .pc_load(w_load), .pc_load_value(w_val), .step(w_step), .pc(w_pc), .led(w_led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      chk("no_step", 64'(step), 64'd0);
    end
  endtask

  task automatic drive(input logic v, input int n);
    step_btn = v;
    repeat (n) begin
      tick();
      nsteps += int'(step);
    end
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; run_en = 1'b1; step_btn = 1'b0; pc_load = 1'b0; pc_load_value = '0;
    w_mode = 1'b1; w_run_en = 1'b0; w_btn = 1'b0; w_load = 1'b0; w_val = '0;
    tick();
    tick();
    chk("rst_pc", 64'(pc), 64'd0);
    chk("rst_step", 64'(step), 64'd0);
    chk("rst_led", 64'(led), 64'd0);
    chk("rst_w_pc", 64'(w_pc), 64'd0);
    rst = 1'b0;
    // free-run: div_cnt after edge e is e mod 8
    for (int e = 1; e <= 24; e++) begin
      tick();
      chk("fr_step", 64'(step), 64'((e % 8) == 0));
      chk("fr_pc", 64'(pc), 64'(e / 8));
      chk("fr_led0", 64'(led[0]), 64'((e % 8) >= 4));
    end
    chk("fr_led", 64'(led), 64'h006);
    run_en = 1'b0;
    idle(8);
    chk("hold_pc", 64'(pc), 64'd3);
    run_en = 1'b1;
    idle(7);
    pc_load = 1'b1; pc_load_value = 16'h0040;
    tick();
    chk("load_pc", 64'(pc), 64'h40);
    chk("load_step", 64'(step), 64'd0);
    pc_load = 1'b0;
    idle(7);
    tick();
    chk("tick_after_load_step", 64'(step), 64'd1);
    chk("tick_after_load_pc", 64'(pc), 64'h41);
    // single-step, button held 40 cycles
    mode = 1'b1; step_btn = 1'b1;
    idle(6);
    tick();
    chk("ss_step", 64'(step), 64'd1);
    chk("ss_pc", 64'(pc), 64'h42);
    idle(33);
    step_btn = 1'b0;
    idle(12);
    chk("ss_hold_pc", 64'(pc), 64'h42);
    step_btn = 1'b1;
    idle(6);
    tick();
    chk("ss2_step", 64'(step), 64'd1);
    chk("ss2_pc", 64'(pc), 64'h43);
    step_btn = 1'b0;
    idle(12);
    // bounce on press and release
    nsteps = 0;
    drive(1'b1, 3); drive(1'b0, 1); drive(1'b1, 2); drive(1'b0, 2);
    drive(1'b1, 20); drive(1'b0, 1); drive(1'b1, 10); drive(1'b0, 12);
    chk("bounce_steps", 64'(nsteps), 64'd1);
    chk("bounce_pc", 64'(pc), 64'h44);
    // press completing in free-run mode with run_en low is lost
    mode = 1'b0; run_en = 1'b0; nsteps = 0;
    drive(1'b1, 15); drive(1'b0, 12);
    chk("mode0_steps", 64'(nsteps), 64'd0);
    chk("mode0_pc", 64'(pc), 64'h44);
    // mode rises while the press is in PRESS_WAIT
    step_btn = 1'b1;
    repeat (4) tick();
    mode = 1'b1;
    idle(2);
    tick();
    chk("mode_rise_step", 64'(step), 64'd1);
    chk("mode_rise_pc", 64'(pc), 64'h45);
    step_btn = 1'b0;
    idle(12);
    // reset mid-press with button still held
    step_btn = 1'b1;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_pc", 64'(pc), 64'd0);
    chk("mid_rst_step", 64'(step), 64'd0);
    chk("mid_rst_led", 64'(led), 64'd0);
    rst = 1'b0;
    idle(6);
    tick();
    chk("post_rst_step", 64'(step), 64'd1);
    chk("post_rst_pc", 64'(pc), 64'd1);
    step_btn = 1'b0;
    // wrap with PC_WIDTH=8, PC_INC=4 and narrow-PC LEDs
    w_load = 1'b1; w_val = 8'hFC;
    tick();
    chk("w_load_pc", 64'(w_pc), 64'hFC);
    chk("w_load_led", 64'(w_led[9:1]), 64'h0FC);
    w_load = 1'b0; w_mode = 1'b0; w_run_en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      seen = w_step;
    end
    chk("w_step_seen", 64'(seen), 64'd1);
    chk("w_wrap_pc", 64'(w_pc), 64'h00);
    chk("w_wrap_led", 64'(w_led[9:1]), 64'h000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
